// File: rtl/led_pkg.sv
// led_pkg: register map, CTRL bit positions and duty width shared by the LED PWM driver
package led_pkg;
    localparam logic [31:0] ADDR_CTRL   = 32'd0;
    localparam logic [31:0] ADDR_STATIC = 32'd1;
    localparam logic [31:0] ADDR_BLINK  = 32'd2;
    localparam logic [31:0] ADDR_DUTY   = 32'd3;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int DUTY_W    = 8;
    typedef enum logic {MODE_STATIC = 1'b0, MODE_PWM = 1'b1} mode_e;
endpackage

// File: rtl/led_pwm_timebase.sv
// led_pwm_timebase: prescaler, 8-bit PWM counter and optional blink counter
//   clk, reset (sync, active low), i_en (counters run when 1, held at 0 when 0)
//   o_cnt  : PWM counter, o_tick : one-cycle pulse at prescaler wrap
//   o_phase: blink phase (MSB of blink counter); 0 unless LED_BLINK_EN is defined
module led_pwm_timebase
    import led_pkg::*;
#(
    parameter int PRESCALE = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    output logic [DUTY_W-1:0] o_cnt,
    output logic              o_tick,
    output logic              o_phase
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0]     r_pre;
    logic [DUTY_W-1:0] r_cnt;
    assign o_tick = i_en && r_pre == PW'(PRESCALE - 1);
    assign o_cnt  = r_cnt;
    always_ff @(posedge clk) begin
        if (!reset || !i_en) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else begin
            r_pre <= o_tick ? '0 : r_pre + 1'b1;
            r_cnt <= r_cnt + DUTY_W'(o_tick);
        end
    end
`ifdef LED_BLINK_EN
    logic [5:0] r_blink_cnt;
    // advances once per PWM period, i.e. on the tick that wraps the counter 255->0
    always_ff @(posedge clk) begin
        if (!reset || !i_en) r_blink_cnt <= '0;
        else if (o_tick && r_cnt == '1) r_blink_cnt <= r_blink_cnt + 1'b1;
    end
    assign o_phase = r_blink_cnt[5];
`else
    assign o_phase = 1'b0;
`endif
endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: register-mapped LED driver with static, PWM and optional blink modes
//   clk, reset (sync, active low)
//   Addr/DataIn/BE/WE : word-addressed register write port with byte enables
//   DataOut           : registered read data for the register at Addr
//   Drive             : registered LED drive, 1 = lit
//   Optional feature macro: LED_BLINK_EN (BLINK mask register and blink phase)
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int CHANNELS = 16,
    parameter int PRESCALE = 100,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   Addr,
    input  logic [31:0]         DataIn,
    input  logic [3:0]          BE,
    input  logic                WE,
    output logic [31:0]         DataOut,
    output logic [CHANNELS-1:0] Drive
);
    logic [1:0]          r_ctrl;
    logic [CHANNELS-1:0] r_static;
    logic [DUTY_W-1:0]   r_duty [CHANNELS];
    logic [31:0]         r_dout;
    logic [CHANNELS-1:0] r_drive;
    logic [31:0]         w_addr;
    logic [CHANNELS-1:0] w_mask;
    logic [CHANNELS-1:0] w_blink;
    logic [CHANNELS-1:0] w_drive;
    logic [31:0]         w_rdata;
    logic [DUTY_W-1:0]   w_cnt;
    logic                w_tick_unused;
    logic                w_phase;
    mode_e               w_mode;
    led_pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
        .clk     (clk),
        .reset   (reset),
        .i_en    (r_ctrl[CTRL_EN]),
        .o_cnt   (w_cnt),
        .o_tick  (w_tick_unused),
        .o_phase (w_phase)
    );
`ifdef LED_BLINK_EN
    logic [CHANNELS-1:0] r_blink;
    always_ff @(posedge clk) begin
        if (!reset) r_blink <= '0;
        else if (WE && w_addr == ADDR_BLINK) r_blink <= (r_blink & ~w_mask) | (DataIn[CHANNELS-1:0] & w_mask);
    end
    assign w_blink = r_blink;
`else
    // without the blink feature address 2 reads 0 and no channel is ever masked
    assign w_blink = '0;
`endif
    always_comb begin
        w_addr  = 32'(Addr);
        w_mode  = mode_e'(r_ctrl[CTRL_MODE]);
        w_mask  = '0;
        w_drive = '0;
        w_rdata = w_addr == ADDR_CTRL   ? 32'(r_ctrl)   :
                  w_addr == ADDR_STATIC ? 32'(r_static) :
                  w_addr == ADDR_BLINK  ? 32'(w_blink)  : '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_mask[i] = BE[i/8];
            if (w_addr == ADDR_DUTY + 32'(i/4)) w_rdata[8*(i%4) +: DUTY_W] = r_duty[i];
            // duty of all-ones is forced on so the channel never drops at cnt == 255
            w_drive[i] = r_ctrl[CTRL_EN] && !(w_blink[i] && w_phase) &&
                         (w_mode == MODE_PWM ? (r_duty[i] == '1 || w_cnt < r_duty[i]) : r_static[i]);
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ctrl   <= '0;
            r_static <= '0;
            r_dout   <= '0;
            r_drive  <= '0;
            for (int i = 0; i < CHANNELS; i++) r_duty[i] <= '0;
        end else begin
            r_dout  <= w_rdata;
            r_drive <= w_drive;
            if (WE && w_addr == ADDR_CTRL) r_ctrl <= (r_ctrl & ~{2{BE[0]}}) | (DataIn[1:0] & {2{BE[0]}});
            if (WE && w_addr == ADDR_STATIC) r_static <= (r_static & ~w_mask) | (DataIn[CHANNELS-1:0] & w_mask);
            for (int i = 0; i < CHANNELS; i++)
                if (WE && w_addr == ADDR_DUTY + 32'(i/4) && BE[i%4]) r_duty[i] <= DataIn[8*(i%4) +: DUTY_W];
        end
    end
    assign DataOut = r_dout;
    assign Drive   = r_drive;
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: randomized and directed checks of led_pwm_driver against a period-arithmetic model
module tb_led_pwm_driver;
    localparam int N = 16;
    localparam int P = 2;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         WE = 1'b0;
    logic [3:0]   Addr = '0;
    logic [3:0]   BE = '0;
    logic [31:0]  DataIn = '0;
    logic [31:0]  DataOut;
    logic [N-1:0] Drive;
    int checks = 0;
    int fails = 0;
    logic [1:0]   m_ctrl;
    logic [N-1:0] m_static;
    logic [N-1:0] m_blink;
    logic [7:0]   m_duty [N];
    int           m_n;
    logic [N-1:0] exp_drive;
    logic [31:0]  exp_dout;

    always #5 clk = ~clk;

    led_pwm_driver #(.CHANNELS(N), .PRESCALE(P), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .DataIn(DataIn),
        .BE(BE), .WE(WE), .DataOut(DataOut), .Drive(Drive)
    );

    // m_n counts enabled clock edges; PWM count and blink phase follow by division
    function automatic logic [N-1:0] model_drive();
        int cnt = (m_n / P) % 256;
        bit phase = 1'b0;
        logic [N-1:0] d = '0;
`ifdef LED_BLINK_EN
        phase = ((m_n / (P * 256)) % 64) >= 32;
`endif
        if (!m_ctrl[0]) return '0;
        for (int i = 0; i < N; i++) begin
            d[i] = m_ctrl[1] ? (m_duty[i] == 8'd255 || cnt < int'(m_duty[i])) : m_static[i];
            if (phase && m_blink[i]) d[i] = 1'b0;
        end
        return d;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        int k = int'(a) - 3;
        if (a == 0) return 32'(m_ctrl);
        if (a == 1) return 32'(m_static);
`ifdef LED_BLINK_EN
        if (a == 2) return 32'(m_blink);
`endif
        if (k >= 0 && k < N / 4) return {m_duty[4*k+3], m_duty[4*k+2], m_duty[4*k+1], m_duty[4*k]};
        return 32'd0;
    endfunction

    task automatic cyc();
        logic [31:0] mask;
        logic [31:0] w;
        int k;
        exp_drive = reset ? model_drive() : '0;
        exp_dout  = reset ? model_read(Addr) : '0;
        @(posedge clk);
        if (!reset) begin
            m_ctrl = '0; m_static = '0; m_blink = '0; m_n = 0;
            for (int i = 0; i < N; i++) m_duty[i] = '0;
        end else begin
            m_n = m_ctrl[0] ? m_n + 1 : 0;
            if (WE) begin
                mask = {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};
                w = (model_read(Addr) & ~mask) | (DataIn & mask);
                k = int'(Addr) - 3;
                if (Addr == 0) m_ctrl = w[1:0];
                else if (Addr == 1) m_static = w[N-1:0];
`ifdef LED_BLINK_EN
                else if (Addr == 2) m_blink = w[N-1:0];
`endif
                else if (k >= 0 && k < N / 4)
                    for (int j = 0; j < 4; j++) m_duty[4*k+j] = w[8*j +: 8];
            end
        end
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        Addr = a; DataIn = d; BE = be; WE = 1'b1;
        cyc();
        WE = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) cyc();
        checks++;
        if (Drive !== '0) begin fails++; $display("FAIL reset_drive: got %h expected 0", Drive); end
        checks++;
        if (DataOut !== '0) begin fails++; $display("FAIL reset_dout: got %h expected 0", DataOut); end
        reset = 1'b1;
        for (int a = 0; a < 7; a++) begin
            Addr = 4'(a);
            cyc();
            checks++;
            if (DataOut !== 32'd0) begin fails++; $display("FAIL reset_reg%0d: got %h expected 0", a, DataOut); end
        end
    endtask

    task automatic test_static();
        wr(4'd0, 32'h1, 4'hF);
        wr(4'd1, 32'h00A5, 4'hF);
        checks++;
        if (Drive !== 16'h0000) begin fails++; $display("FAIL static_latency: got %h expected 0000", Drive); end
        cyc();
        checks++;
        if (Drive !== 16'h00A5) begin fails++; $display("FAIL static_drive: got %h expected 00a5", Drive); end
        checks++;
        if (Drive !== exp_drive) begin fails++; $display("FAIL static_model: got %h expected %h", Drive, exp_drive); end
    endtask

    task automatic test_byte_enable();
        wr(4'd1, 32'h0, 4'hF);
        wr(4'd1, 32'hFFFF_FFFF, 4'h1);
        Addr = 4'd1;
        cyc();
        checks++;
        if (DataOut !== 32'h0000_00FF) begin fails++; $display("FAIL be_read: got %h expected 000000ff", DataOut); end
        checks++;
        if (Drive !== 16'h00FF) begin fails++; $display("FAIL be_drive: got %h expected 00ff", Drive); end
        wr(4'd9, 32'hDEAD_BEEF, 4'hF);
        wr(4'd2, 32'h0000_0003, 4'hF);
        for (int a = 0; a < 16; a++) begin
            Addr = 4'(a);
            cyc();
            checks++;
            if (DataOut !== exp_dout) begin fails++; $display("FAIL map_read%0d: got %h expected %h", a, DataOut, exp_dout); end
        end
        Addr = 4'd9;
        cyc();
        checks++;
        if (DataOut !== 32'd0) begin fails++; $display("FAIL unmapped_read: got %h expected 0", DataOut); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            WE = 1'($urandom_range(0, 1));
            Addr = 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 6));
            DataIn = $urandom;
            BE = 4'($urandom);
            cyc();
            checks++;
            if (DataOut !== exp_dout) begin fails++; $display("FAIL rand_dout@%0d: got %h expected %h", c, DataOut, exp_dout); end
            checks++;
            if (Drive !== exp_drive) begin fails++; $display("FAIL rand_drive@%0d: got %h expected %h", c, Drive, exp_drive); end
        end
        WE = 1'b0;
    endtask

    task automatic test_pwm_duty();
        int high = 0;
        wr(4'd0, 32'h0, 4'hF);
        wr(4'd3, 32'h0000_0040, 4'hF);
        for (int a = 4; a < 7; a++) wr(4'(a), 32'h0, 4'hF);
        wr(4'd0, 32'h3, 4'hF);
        for (int c = 0; c < 1024; c++) begin
            cyc();
            if (c >= 512 && Drive[0]) high++;
            checks++;
            if (Drive !== exp_drive) begin fails++; $display("FAIL pwm_drive@%0d: got %h expected %h", c, Drive, exp_drive); end
        end
        checks++;
        if (high != 128) begin fails++; $display("FAIL pwm_duty64: got %0d high cycles expected 128", high); end
    endtask

    task automatic test_override();
        wr(4'd3, 32'h0000_FF40, 4'hF);
        cyc();
        for (int c = 0; c < 600; c++) begin
            cyc();
            checks++;
            if (Drive[2:1] !== 2'b01) begin fails++; $display("FAIL override@%0d: got %b expected 01", c, Drive[2:1]); end
            checks++;
            if (Drive !== exp_drive) begin fails++; $display("FAIL override_model@%0d: got %h expected %h", c, Drive, exp_drive); end
        end
    endtask

    task automatic test_mid_change();
        for (int s = 0; s < 6; s++) begin
            case (s % 3)
                0: wr(4'($urandom_range(3, 6)), $urandom, 4'hF);
                1: wr(4'd0, 32'h1, 4'hF);
                default: wr(4'd0, 32'h3, 4'hF);
            endcase
            for (int c = 0; c < 150; c++) begin
                cyc();
                checks++;
                if (Drive !== exp_drive) begin fails++; $display("FAIL mid_change%0d@%0d: got %h expected %h", s, c, Drive, exp_drive); end
            end
        end
    endtask

    task automatic test_enable_off();
        wr(4'd0, 32'h2, 4'hF);
        for (int c = 0; c < 20; c++) begin
            cyc();
            checks++;
            if (Drive !== '0) begin fails++; $display("FAIL en_off@%0d: got %h expected 0", c, Drive); end
        end
        wr(4'd0, 32'h3, 4'hF);
        for (int c = 0; c < 300; c++) begin
            cyc();
            checks++;
            if (Drive !== exp_drive) begin fails++; $display("FAIL en_restart@%0d: got %h expected %h", c, Drive, exp_drive); end
        end
    endtask

    task automatic test_reset_mid();
        wr(4'd0, 32'h3, 4'hF);
        repeat (77) cyc();
        reset = 1'b0;
        wr(4'd1, 32'hFFFF, 4'hF);
        checks++;
        if (Drive !== '0) begin fails++; $display("FAIL rst_mid_drive: got %h expected 0", Drive); end
        checks++;
        if (DataOut !== '0) begin fails++; $display("FAIL rst_mid_dout: got %h expected 0", DataOut); end
        reset = 1'b1;
        for (int a = 0; a < 7; a++) begin
            Addr = 4'(a);
            cyc();
            checks++;
            if (DataOut !== 32'd0) begin fails++; $display("FAIL rst_mid_reg%0d: got %h expected 0", a, DataOut); end
            checks++;
            if (Drive !== '0) begin fails++; $display("FAIL rst_mid_hold%0d: got %h expected 0", a, Drive); end
        end
    endtask

`ifdef LED_BLINK_EN
    task automatic test_blink();
        int toggles = 0;
        logic prev;
        wr(4'd2, 32'h1, 4'hF);
        wr(4'd1, 32'h1, 4'hF);
        wr(4'd0, 32'h1, 4'hF);
        cyc();
        prev = Drive[0];
        checks++;
        if (Drive[0] !== 1'b1) begin fails++; $display("FAIL blink_start: got %b expected 1", Drive[0]); end
        for (int c = 0; c < 34000; c++) begin
            cyc();
            if (Drive[0] !== prev) toggles++;
            prev = Drive[0];
            if (Drive !== exp_drive) begin
                checks++; fails++;
                $display("FAIL blink_model@%0d: got %h expected %h", c, Drive, exp_drive);
            end
        end
        checks++;
        if (toggles != 2) begin fails++; $display("FAIL blink_toggles: got %0d expected 2", toggles); end
    endtask
`endif

    initial begin
        test_reset();
        test_static();
        test_byte_enable();
        test_random();
        test_pwm_duty();
        test_override();
        test_mid_change();
        test_enable_off();
        test_reset_mid();
`ifdef LED_BLINK_EN
        test_blink();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
